// File: rtl/rgb2tmds_encoder.sv
// DVI 1.0 TMDS encoder: one RGB888 pixel plus sync/DE per clock in, three 10-bit
// symbols per clock out (transition minimisation, DC balance, control tokens).
module rgb2tmds_encoder #(
    parameter bit OUT_REG = 1'b1,
    parameter bit SWAP_RB = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       hsync,
    input  logic       data_valid,
    input  logic [7:0] data0_r,
    input  logic [7:0] data0_g,
    input  logic [7:0] data0_b,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2,
    output logic       tmds_valid
);

    localparam int unsigned DW  = 8;
    localparam int unsigned QW  = DW + 1;
    localparam int unsigned SW  = 10;
    localparam int unsigned CW  = 5;
    localparam int unsigned NW  = 4;
    localparam int unsigned NCH = 3;

    localparam logic [SW-1:0] TOK_00 = 10'h354;
    localparam logic [SW-1:0] TOK_01 = 10'h0AB;
    localparam logic [SW-1:0] TOK_10 = 10'h154;
    localparam logic [SW-1:0] TOK_11 = 10'h2AB;

    localparam logic signed [CW-1:0] CNT_ZERO = '0;

    // Stage-0 payload; data[2]/[1]/[0] feed ch2/ch1/ch0 after the optional R/B swap.
    typedef struct packed {
        logic                   de;
        logic [1:0]             ctl;
        logic [NCH-1:0][DW-1:0] data;
        logic [NCH-1:0][NW-1:0] ones;
    } s0_t;

    typedef struct packed {
        logic [SW-1:0]        sym;
        logic signed [CW-1:0] cnt;
    } bal_t;

    function automatic logic [SW-1:0] token(input logic [1:0] c);
        logic [SW-1:0] t;
        case (c)
            2'b00:   t = TOK_00;
            2'b01:   t = TOK_01;
            2'b10:   t = TOK_10;
            default: t = TOK_11;
        endcase
        return t;
    endfunction

    // XOR/XNOR chain chosen to minimise transitions; q[8] records which one.
    function automatic logic [QW-1:0] tm_encode(input logic [DW-1:0] d,
                                                input logic [NW-1:0] ones);
        logic          use_xnor;
        logic [QW-1:0] q;
        use_xnor = (ones > NW'(4)) || ((ones == NW'(4)) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < int'(DW); i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[QW-1] = ~use_xnor;
        return q;
    endfunction

    // Running-disparity selection; cnt always equals the summed symbol disparity.
    function automatic bal_t dc_balance(input logic [QW-1:0]        qm,
                                        input logic signed [CW-1:0] cnt);
        bal_t                 r;
        logic [NW-1:0]        n1;
        logic signed [CW-1:0] diff;
        logic signed [CW-1:0] q8x2;
        logic signed [CW-1:0] nq8x2;
        n1    = NW'($countones(qm[DW-1:0]));
        diff  = $signed({n1, 1'b0} - CW'(8));
        q8x2  = qm[QW-1] ? CW'(2) : '0;
        nq8x2 = qm[QW-1] ? '0 : CW'(2);
        r.sym = '0;
        r.cnt = cnt;
        if ((cnt == CNT_ZERO) || (diff == CNT_ZERO)) begin
            r.sym = {~qm[QW-1], qm[QW-1], qm[QW-1] ? qm[DW-1:0] : ~qm[DW-1:0]};
            r.cnt = qm[QW-1] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > CNT_ZERO) && (diff > CNT_ZERO)) ||
                     ((cnt < CNT_ZERO) && (diff < CNT_ZERO))) begin
            r.sym = {1'b1, qm[QW-1], ~qm[DW-1:0]};
            r.cnt = cnt + q8x2 - diff;
        end else begin
            r.sym = {1'b0, qm[QW-1], qm[DW-1:0]};
            r.cnt = cnt + diff - nq8x2;
        end
        return r;
    endfunction

    s0_t                  s0_d, s0_q;
    logic                 v0_q;
    logic [SW-1:0]        sym_c [NCH];
    logic signed [CW-1:0] cnt_d [NCH];
    logic signed [CW-1:0] cnt_q [NCH];

    always_comb begin
        s0_d         = '0;
        s0_d.de      = data_valid;
        s0_d.ctl     = {vsync, hsync};
        s0_d.data[2] = SWAP_RB ? data0_b : data0_r;
        s0_d.data[1] = data0_g;
        s0_d.data[0] = SWAP_RB ? data0_r : data0_b;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            s0_d.ones[ch] = NW'($countones(s0_d.data[ch]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_q <= '0;
            v0_q <= 1'b0;
        end else begin
            s0_q <= s0_d;
            v0_q <= 1'b1;
        end
    end

    // Control periods emit tokens and zero the disparity so each active run starts fresh.
    always_comb begin
        bal_t bal;
        bal = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            sym_c[ch] = token((ch == 0) ? s0_q.ctl : 2'b00);
            cnt_d[ch] = '0;
            if (s0_q.de) begin
                bal       = dc_balance(tm_encode(s0_q.data[ch], s0_q.ones[ch]), cnt_q[ch]);
                sym_c[ch] = bal.sym;
                cnt_d[ch] = bal.cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < int'(NCH); ch++) begin
            if (!reset) begin
                cnt_q[ch] <= '0;
            end else begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [SW-1:0] sym_q [NCH];
            logic          v1_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    v1_q <= 1'b0;
                end else begin
                    v1_q <= v0_q;
                end
                for (int ch = 0; ch < int'(NCH); ch++) begin
                    if (!reset) begin
                        sym_q[ch] <= TOK_00;
                    end else begin
                        sym_q[ch] <= sym_c[ch];
                    end
                end
            end

            assign tmds_ch0   = sym_q[0];
            assign tmds_ch1   = sym_q[1];
            assign tmds_ch2   = sym_q[2];
            assign tmds_valid = v1_q;
        end else begin : g_comb
            assign tmds_ch0   = sym_c[0];
            assign tmds_ch1   = sym_c[1];
            assign tmds_ch2   = sym_c[2];
            assign tmds_valid = v0_q;
        end
    endgenerate

endmodule

// File: tb/tb_rgb2tmds_encoder.sv
// Bench for rgb2tmds_encoder: a latency-2 unswapped instance and a latency-1
// R/B-swapped instance share stimulus; a scoreboard queue per instance holds expectations.
module tb_rgb2tmds_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b0;
    logic       hsync = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data0_r = '0;
    logic [7:0] data0_g = '0;
    logic [7:0] data0_b = '0;
    logic [9:0] a_ch0, a_ch1, a_ch2;
    logic [9:0] s_ch0, s_ch1, s_ch2;
    logic       a_valid, s_valid;

    always #5 clk = ~clk;

    rgb2tmds_encoder #(.OUT_REG(1'b1), .SWAP_RB(1'b0)) u_a (
        .clk(clk), .reset(reset), .vsync(vsync), .hsync(hsync),
        .data_valid(data_valid), .data0_r(data0_r), .data0_g(data0_g), .data0_b(data0_b),
        .tmds_ch0(a_ch0), .tmds_ch1(a_ch1), .tmds_ch2(a_ch2), .tmds_valid(a_valid)
    );

    rgb2tmds_encoder #(.OUT_REG(1'b0), .SWAP_RB(1'b1)) u_s (
        .clk(clk), .reset(reset), .vsync(vsync), .hsync(hsync),
        .data_valid(data_valid), .data0_r(data0_r), .data0_g(data0_g), .data0_b(data0_b),
        .tmds_ch0(s_ch0), .tmds_ch1(s_ch1), .tmds_ch2(s_ch2), .tmds_valid(s_valid)
    );

    typedef struct {
        logic        de;
        logic [1:0]  ctl;
        logic [7:0]  d [3];
        logic [29:0] exp;
    } sb_t;

    typedef struct {
        logic       de, vs, hs;
        logic [7:0] r, g, b;
        logic [9:0] a2, a1, a0, s2, s0;
    } vec_t;

    sb_t q_a[$];
    sb_t q_s[$];
    int  cnt_m  [2][3];
    int  disp_m [2][3];
    int  n_pass = 0;
    int  n_chk  = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    task automatic chk_rng(input string name, input int v, input int lim);
        n_chk++;
        if (v >= -lim && v <= lim) n_pass++;
        else $display("FAIL %s: got %0d want within +/-%0d", name, v, lim);
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cnt_i, output int cnt_o);
        int         nd, ones, diff, q8;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] sym;
        nd    = $countones(d);
        xn    = (nd > 4) || (nd == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        q8    = qm[8] ? 1 : 0;
        ones  = $countones(qm[7:0]);
        diff  = ones - (8 - ones);
        if (cnt_i == 0 || diff == 0) begin
            sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_o = (q8 == 1) ? cnt_i + diff : cnt_i - diff;
        end else if ((cnt_i > 0 && diff > 0) || (cnt_i < 0 && diff < 0)) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            cnt_o = cnt_i + 2 * q8 - diff;
        end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            cnt_o = cnt_i + diff - 2 * (1 - q8);
        end
        return sym;
    endfunction

    // Independent receiver-side decode: {is_control, C[1:0], data[7:0]}.
    function automatic logic [10:0] tmds_dec(input logic [9:0] s);
        logic [7:0] q, d;
        case (s)
            10'h354: return {1'b1, 2'b00, 8'h00};
            10'h0AB: return {1'b1, 2'b01, 8'h00};
            10'h154: return {1'b1, 2'b10, 8'h00};
            10'h2AB: return {1'b1, 2'b11, 8'h00};
            default: begin
                q    = s[9] ? ~s[7:0] : s[7:0];
                d    = '0;
                d[0] = q[0];
                for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                return {1'b0, 2'b00, d};
            end
        endcase
    endfunction

    task automatic model_push(input int w, input logic de, input logic [1:0] ctl,
                              input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                              input bit use_tab, input logic [29:0] tab);
        sb_t        e;
        int         co;
        logic [9:0] sym;
        e.de   = de;
        e.ctl  = ctl;
        e.d[0] = d0;
        e.d[1] = d1;
        e.d[2] = d2;
        e.exp  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            if (de) begin
                sym = ref_enc(e.d[ch], cnt_m[w][ch], co);
                cnt_m[w][ch] = co;
            end else begin
                sym = tok((ch == 0) ? ctl : 2'b00);
                cnt_m[w][ch] = 0;
            end
            e.exp[ch*10 +: 10] = sym;
        end
        if (use_tab) e.exp = tab;
        if (w == 0) q_a.push_back(e);
        else q_s.push_back(e);
    endtask

    task automatic check_entry(input int w, input string tag, input sb_t e,
                               input logic [29:0] syms, input logic v);
        logic [9:0]  sym;
        logic [10:0] want;
        chk_eq({tag, "_valid"}, 32'(v), 32'd1);
        chk_eq({tag, "_sym"}, 32'(syms), 32'(e.exp));
        for (int ch = 0; ch < 3; ch++) begin
            sym  = syms[ch*10 +: 10];
            want = e.de ? {1'b0, 2'b00, e.d[ch]} : {1'b1, (ch == 0) ? e.ctl : 2'b00, 8'h00};
            chk_eq($sformatf("%s_dec%0d", tag, ch), 32'(tmds_dec(sym)), 32'(want));
            if (e.de) begin
                disp_m[w][ch] += 2 * $countones(sym) - 10;
                chk_rng($sformatf("%s_disp%0d", tag, ch), disp_m[w][ch], 8);
            end else begin
                disp_m[w][ch] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        sb_t e;
        if (q_s.size() >= 1) begin
            e = q_s.pop_front();
            check_entry(1, "swp", e, {s_ch2, s_ch1, s_ch0}, s_valid);
        end else begin
            chk_eq("swp_idle_valid", 32'(s_valid), 32'd0);
            chk_eq("swp_idle_sym", 32'({s_ch2, s_ch1, s_ch0}), 32'({3{10'h354}}));
        end
        if (q_a.size() >= 2) begin
            e = q_a.pop_front();
            check_entry(0, "reg", e, {a_ch2, a_ch1, a_ch0}, a_valid);
        end else begin
            chk_eq("reg_idle_valid", 32'(a_valid), 32'd0);
            chk_eq("reg_idle_sym", 32'({a_ch2, a_ch1, a_ch0}), 32'({3{10'h354}}));
        end
    endtask

    task automatic cycle(input logic de, input logic vs, input logic hs,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         input bit use_tab, input logic [29:0] ta, input logic [29:0] ts);
        @(negedge clk);
        check_outputs();
        reset      = 1'b1;
        data_valid = de;
        vsync      = vs;
        hsync      = hs;
        data0_r    = rr;
        data0_g    = gg;
        data0_b    = bb;
        model_push(0, de, {vs, hs}, rr, gg, bb, use_tab, ta);
        model_push(1, de, {vs, hs}, bb, gg, rr, use_tab, ts);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        q_a.delete();
        q_s.delete();
        for (int w = 0; w < 2; w++) begin
            for (int ch = 0; ch < 3; ch++) begin
                cnt_m[w][ch]  = 0;
                disp_m[w][ch] = 0;
            end
        end
    endtask

    function automatic vec_t mk(input logic de, input logic vs, input logic hs,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic [9:0] a2, input logic [9:0] a1, input logic [9:0] a0,
                                input logic [9:0] s2, input logic [9:0] s0);
        vec_t v;
        v.de = de; v.vs = vs; v.hs = hs;
        v.r = r; v.g = g; v.b = b;
        v.a2 = a2; v.a1 = a1; v.a0 = a0; v.s2 = s2; v.s0 = s0;
        return v;
    endfunction

    initial begin
        vec_t tab [19];
        logic de_r;
        int   run;

        tab[0]  = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
        tab[1]  = mk(0, 0, 1, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h0AB, 10'h354, 10'h0AB);
        tab[2]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h154, 10'h354, 10'h154);
        tab[3]  = mk(0, 1, 1, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h2AB, 10'h354, 10'h2AB);
        tab[4]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100, 10'h100, 10'h100);
        tab[5]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
        tab[6]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100, 10'h100, 10'h100);
        tab[7]  = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
        tab[8]  = mk(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200);
        tab[9]  = mk(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF);
        tab[10] = mk(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF);
        tab[11] = mk(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200);
        tab[12] = mk(0, 0, 1, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h0AB, 10'h354, 10'h0AB);
        tab[13] = mk(1, 0, 0, 8'hFF, 8'h55, 8'h00, 10'h200, 10'h133, 10'h100, 10'h100, 10'h200);
        tab[14] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
        tab[15] = mk(1, 0, 0, 8'h00, 8'h10, 8'h55, 10'h100, 10'h1F0, 10'h133, 10'h133, 10'h100);
        tab[16] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);
        tab[17] = mk(1, 0, 0, 8'h00, 8'h00, 8'hFF, 10'h100, 10'h100, 10'h200, 10'h200, 10'h100);
        tab[18] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354);

        for (int i = 0; i < 5; i++) reset_cycle();

        for (int i = 0; i < 19; i++) begin
            cycle(tab[i].de, tab[i].vs, tab[i].hs, tab[i].r, tab[i].g, tab[i].b, 1'b1,
                  {tab[i].a2, tab[i].a1, tab[i].a0}, {tab[i].s2, tab[i].a1, tab[i].s0});
        end

        // Reset in the middle of an active run must drop the accumulated disparity.
        cycle(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1'b0, '0, '0);
        cycle(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1'b0, '0, '0);
        reset_cycle();
        cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, {3{10'h100}}, {3{10'h100}});
        cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, {3{10'h3FF}}, {3{10'h3FF}});
        cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0, '0);

        de_r = 1'b0;
        run  = 0;
        for (int k = 0; k < 1000; k++) begin
            if (run == 0) begin
                de_r = ~de_r;
                run  = $urandom_range(1, 24);
            end
            run--;
            if (k == 600) reset_cycle();
            cycle(de_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), 8'($urandom), 1'b0, '0, '0);
        end

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
